// File: rtl/alu_op_sequencer.sv
// Command front-end for the 32-bit ALU: accepts one op at a time, sequences
// single-pass, EQ (one SUB pass) and MUL (shift-add through ALU ADD) commands.
module alu_op_sequencer #(
    parameter int WIDTH    = 32,
    parameter int MUL_ITER = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [3:0]       req_op,
    input  logic [WIDTH-1:0] req_a,
    input  logic [WIDTH-1:0] req_b,
    output logic [3:0]       ALU_Control,
    output logic [WIDTH-1:0] operand_A,
    output logic [WIDTH-1:0] operand_B,
    input  logic [WIDTH-1:0] ALU_result,
    input  logic             zero,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [WIDTH-1:0] rsp_result,
    output logic             rsp_zero
);

    localparam int CNT_W = (MUL_ITER > 1) ? $clog2(MUL_ITER) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MUL_ITER - 1);

    localparam logic [3:0] OP_AND = 4'b0000;
    localparam logic [3:0] OP_OR  = 4'b0001;
    localparam logic [3:0] OP_ADD = 4'b0010;
    localparam logic [3:0] OP_SUB = 4'b0110;
    localparam logic [3:0] OP_SLT = 4'b0111;
    localparam logic [3:0] OP_NOR = 4'b1100;
    localparam logic [3:0] OP_EQ  = 4'b1001;
    localparam logic [3:0] OP_MUL = 4'b1000;

    typedef enum logic [1:0] {
        IDLE,
        EXEC,
        MUL,
        DONE
    } state_t;

    state_t           state;
    logic             is_eq;
    logic [WIDTH-1:0] mcand;
    logic [WIDTH-1:0] mplier;
    logic [CNT_W-1:0] cnt;

    // ALU drive is registered and set up one edge ahead of the cycle that uses
    // it; during MUL, operand_A doubles as the product accumulator.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            req_ready   <= 1'b1;
            rsp_valid   <= 1'b0;
            rsp_result  <= '0;
            rsp_zero    <= 1'b0;
            ALU_Control <= OP_ADD;
            operand_A   <= '0;
            operand_B   <= '0;
            is_eq       <= 1'b0;
            mcand       <= '0;
            mplier      <= '0;
            cnt         <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid && req_ready) begin
                        req_ready <= 1'b0;
                        case (req_op)
                            OP_AND, OP_OR, OP_ADD, OP_SUB, OP_SLT, OP_NOR: begin
                                ALU_Control <= req_op;
                                operand_A   <= req_a;
                                operand_B   <= req_b;
                                is_eq       <= 1'b0;
                                state       <= EXEC;
                            end
                            OP_EQ: begin
                                ALU_Control <= OP_SUB;
                                operand_A   <= req_a;
                                operand_B   <= req_b;
                                is_eq       <= 1'b1;
                                state       <= EXEC;
                            end
                            OP_MUL: begin
                                ALU_Control <= OP_ADD;
                                operand_A   <= '0;
                                operand_B   <= req_b[0] ? req_a : '0;
                                mcand       <= req_a;
                                mplier      <= req_b;
                                cnt         <= '0;
                                state       <= MUL;
                            end
                            default: begin
                                rsp_result <= '0;
                                rsp_zero   <= 1'b1;
                                rsp_valid  <= 1'b1;
                                state      <= DONE;
                            end
                        endcase
                    end
                end
                EXEC: begin
                    if (is_eq) begin
                        rsp_result <= {{(WIDTH-1){1'b0}}, zero};
                        rsp_zero   <= ~zero;
                    end else begin
                        rsp_result <= ALU_result;
                        rsp_zero   <= (ALU_result == '0);
                    end
                    ALU_Control <= OP_ADD;
                    operand_A   <= '0;
                    operand_B   <= '0;
                    rsp_valid   <= 1'b1;
                    state       <= DONE;
                end
                MUL: begin
                    mcand  <= mcand << 1;
                    mplier <= mplier >> 1;
                    cnt    <= cnt + CNT_W'(1);
                    if (cnt == CNT_LAST) begin
                        rsp_result  <= ALU_result;
                        rsp_zero    <= zero;
                        rsp_valid   <= 1'b1;
                        ALU_Control <= OP_ADD;
                        operand_A   <= '0;
                        operand_B   <= '0;
                        state       <= DONE;
                    end else begin
                        // next partial product uses the next multiplier bit
                        operand_A <= ALU_result;
                        operand_B <= mplier[1] ? (mcand << 1) : '0;
                    end
                end
                DONE: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        req_ready <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Self-checking bench for alu_op_sequencer: behavioural ALU, directed vector
// table, randomized commands against an arithmetic reference, and corner sequences.
module tb_alu_op_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic [3:0]  req_op;
    logic [31:0] req_a;
    logic [31:0] req_b;
    logic [3:0]  ALU_Control;
    logic [31:0] operand_A;
    logic [31:0] operand_B;
    logic [31:0] ALU_result;
    logic        zero;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_result;
    logic        rsp_zero;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    alu_op_sequencer #(.WIDTH(32), .MUL_ITER(32)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
        .req_a(req_a), .req_b(req_b),
        .ALU_Control(ALU_Control), .operand_A(operand_A), .operand_B(operand_B),
        .ALU_result(ALU_result), .zero(zero),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_result(rsp_result), .rsp_zero(rsp_zero)
    );

    // The ALU the sequencer drives (unsigned SLT)
    always_comb begin
        ALU_result = '0;
        case (ALU_Control)
            4'b0000: ALU_result = operand_A & operand_B;
            4'b0001: ALU_result = operand_A | operand_B;
            4'b0010: ALU_result = operand_A + operand_B;
            4'b0110: ALU_result = operand_A - operand_B;
            4'b0111: ALU_result = {31'b0, operand_A < operand_B};
            4'b1100: ALU_result = ~(operand_A | operand_B);
            default: ALU_result = '0;
        endcase
    end
    assign zero = (ALU_result == 32'd0);

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, required %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: what each command means, independent of how it is sequenced
    function automatic void model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] res, output logic z, output int lat,
                                  output logic [3:0] exec_ctl);
        logic [63:0] prod;
        lat = 2;
        exec_ctl = op;
        case (op)
            4'b0000: res = a & b;
            4'b0001: res = a | b;
            4'b0010: res = a + b;
            4'b0110: res = a - b;
            4'b0111: res = (a < b) ? 32'd1 : 32'd0;
            4'b1100: res = ~(a | b);
            4'b1001: begin res = (a == b) ? 32'd1 : 32'd0; exec_ctl = 4'b0110; end
            4'b1000: begin prod = {32'd0, a} * {32'd0, b}; res = prod[31:0]; lat = 33; exec_ctl = 4'b0010; end
            default: begin res = 32'd0; lat = 1; exec_ctl = 4'b0010; end
        endcase
        z = (res == 32'd0);
    endfunction

    // Issue one command from IDLE, stall the response `stall` cycles, then
    // complete the handshake. Optionally keep req_valid high with another op.
    task automatic run_cmd(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                           input int stall, input bit keep_req, input string tag);
        logic [31:0] exp_res;
        logic        exp_z;
        int          exp_lat;
        logic [3:0]  exp_ctl;
        logic [3:0]  want_ctl;
        logic [31:0] held;
        int          lat;
        int          guard;
        bit          ctl_ok;
        model(op, a, b, exp_res, exp_z, exp_lat, exp_ctl);
        req_valid = 1'b1; req_op = op; req_a = a; req_b = b;
        rsp_ready = (stall == 0);
        guard = 0;
        while (!req_ready && guard < 100) begin @(posedge clk); #1; guard++; end
        check({tag, " ready_wait"}, {31'b0, req_ready}, 32'd1);
        @(posedge clk); #1;
        if (keep_req) begin
            req_op = 4'b0010; req_a = $urandom; req_b = $urandom;
        end else begin
            req_valid = 1'b0;
        end
        lat = 1;
        ctl_ok = 1'b1;
        while (!rsp_valid && lat < 100) begin
            want_ctl = (lat == 1 && exp_lat == 2) ? exp_ctl : 4'b0010;
            if (ALU_Control !== want_ctl || req_ready !== 1'b0) ctl_ok = 1'b0;
            @(posedge clk); #1; lat++;
        end
        check({tag, " latency"}, lat, exp_lat);
        check({tag, " alu_ctl"}, {31'b0, ctl_ok}, 32'd1);
        check({tag, " result"}, rsp_result, exp_res);
        check({tag, " zero"}, {31'b0, rsp_zero}, {31'b0, exp_z});
        held = rsp_result;
        for (int s = 0; s < stall; s++) begin
            @(posedge clk); #1;
            if (s == stall - 1) begin
                check({tag, " stall_hold"}, rsp_result, held);
                check({tag, " stall_valid"}, {31'b0, rsp_valid}, 32'd1);
                check({tag, " stall_req_ready"}, {31'b0, req_ready}, 32'd0);
            end
        end
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        check({tag, " post_valid"}, {31'b0, rsp_valid}, 32'd0);
        check({tag, " post_req_ready"}, {31'b0, req_ready}, 32'd1);
    endtask

    typedef struct {
        logic [3:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] res;
        logic        z;
        int          lat;
    } vec_t;

    vec_t vecs[12];

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [3:0]  ops[8];
        bit          seen_valid;

        vecs[0]  = '{4'b0010, 32'h0000_0005, 32'h0000_0003, 32'h0000_0008, 1'b0, 2};
        vecs[1]  = '{4'b0110, 32'h0000_0007, 32'h0000_0007, 32'h0000_0000, 1'b1, 2};
        vecs[2]  = '{4'b0111, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 1'b1, 2};
        vecs[3]  = '{4'b1100, 32'h0000_0000, 32'h0000_0000, 32'hFFFF_FFFF, 1'b0, 2};
        vecs[4]  = '{4'b1001, 32'h1234_5678, 32'h1234_5678, 32'h0000_0001, 1'b0, 2};
        vecs[5]  = '{4'b1001, 32'h0000_0001, 32'h0000_0002, 32'h0000_0000, 1'b1, 2};
        vecs[6]  = '{4'b1000, 32'h0000_1234, 32'h0000_0010, 32'h0001_2340, 1'b0, 33};
        vecs[7]  = '{4'b1000, 32'h8000_0000, 32'h0000_0002, 32'h0000_0000, 1'b1, 33};
        vecs[8]  = '{4'b1000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 33};
        vecs[9]  = '{4'b1111, 32'h1234_0000, 32'h0000_5678, 32'h0000_0000, 1'b1, 1};
        vecs[10] = '{4'b0000, 32'hF0F0_1234, 32'h0FF0_FF00, 32'h00F0_1200, 1'b0, 2};
        vecs[11] = '{4'b0001, 32'hF000_0000, 32'h0000_000F, 32'hF000_000F, 1'b0, 2};

        ops = '{4'b0000, 4'b0001, 4'b0010, 4'b0110, 4'b0111, 4'b1100, 4'b1001, 4'b1000};

        rst = 1'b1; req_valid = 1'b0; req_op = '0; req_a = '0; req_b = '0; rsp_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        check("reset req_ready", {31'b0, req_ready}, 32'd1);
        check("reset rsp_valid", {31'b0, rsp_valid}, 32'd0);
        check("reset rsp_result", rsp_result, 32'd0);
        check("reset rsp_zero", {31'b0, rsp_zero}, 32'd0);
        check("reset alu_ctl", {28'b0, ALU_Control}, 32'd2);
        check("reset operands", operand_A | operand_B, 32'd0);

        // Directed table: the expected columns are fixed constants
        for (int i = 0; i < 12; i++) begin
            logic [31:0] r; logic z; int l; logic [3:0] c;
            model(vecs[i].op, vecs[i].a, vecs[i].b, r, z, l, c);
            check($sformatf("table%0d ref_res", i), r, vecs[i].res);
            check($sformatf("table%0d ref_lat", i), l, vecs[i].lat);
            run_cmd(vecs[i].op, vecs[i].a, vecs[i].b, 0, 1'b0, $sformatf("table%0d", i));
        end

        // Backpressure with a new request held valid during the stall
        run_cmd(4'b0010, 32'd100, 32'd23, 5, 1'b1, "bp_add");
        // req_valid is still high with an ADD: it must be accepted now, not on the handshake edge
        run_cmd(4'b0110, 32'd50, 32'd8, 0, 1'b0, "bp_next");

        // Reset at MUL iteration 10 must discard the command
        req_valid = 1'b1; req_op = 4'b1000; req_a = 32'd77; req_b = 32'd99; rsp_ready = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("mulrst req_ready", {31'b0, req_ready}, 32'd1);
        check("mulrst rsp_valid", {31'b0, rsp_valid}, 32'd0);
        check("mulrst alu_ctl", {28'b0, ALU_Control}, 32'd2);
        check("mulrst operands", operand_A | operand_B, 32'd0);
        seen_valid = 1'b0;
        for (int c = 0; c < 40; c++) begin
            @(posedge clk); #1;
            if (rsp_valid) seen_valid = 1'b1;
        end
        check("mulrst no_response", {31'b0, seen_valid}, 32'd0);
        rsp_ready = 1'b0;

        // Randomized commands, mostly legal, random operand shapes and stalls
        for (int n = 0; n < 150; n++) begin
            op = ($urandom_range(0, 9) == 0) ? 4'($urandom) : ops[$urandom_range(0, 7)];
            case ($urandom_range(0, 3))
                0: begin a = $urandom; b = a; end
                1: begin a = $urandom_range(0, 15); b = $urandom_range(0, 15); end
                default: begin a = $urandom; b = $urandom; end
            endcase
            run_cmd(op, a, b, $urandom_range(0, 3), 1'b0, $sformatf("rand%0d op%b", n, op));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
